// File: rtl/iir_wb_sequencer.sv
// Wishbone master that feeds buffered samples into the IIR filter slave (write X,
// settle, read Y) and returns each filtered result on an output valid/ready stream.
module iir_wb_sequencer #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 7,
    parameter logic [ADDR_WIDTH-1:0] ADDR_X        = 7'h3C,
    parameter logic [ADDR_WIDTH-1:0] ADDR_Y        = 7'h40,
    parameter int                    FIFO_DEPTH    = 4,
    parameter int                    SETTLE_CYCLES = 2,
    parameter int                    ACK_TIMEOUT   = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  enable_i,
    input  logic                  clear_err_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [DATA_WIDTH-1:0] wbm_dat_o,
    input  logic [DATA_WIDTH-1:0] wbm_dat_i,
    output logic                  wbm_we_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_cyc_o,
    input  logic                  wbm_ack_i,
    output logic                  busy_o,
    output logic                  timeout_err_o,
    output logic [15:0]           sample_cnt_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int ST_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_SETTLE,
        ST_RD,
        ST_OUT
    } state_e;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // Ready only follows the registered pointers, so a same-cycle pop never frees a full FIFO.
    assign s_ready_o = !fifo_full && wb_rst_n_i;
    assign push      = s_valid_i && s_ready_o;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;
    end

    // NOTE: storage array has no reset; emptiness is defined by the pointers alone,
    // which keeps the array mappable to plain RAM/regfile cells.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= s_data_i;
        end
    end

    // ------------------------------------------------------------ sequencer
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  we_q, we_d;
    logic                  cyc_q, cyc_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [ST_W-1:0]       settle_q, settle_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  timeout_set;
    logic                  to_hit;

    assign to_hit = (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));

    // NOTE: every signal assigned here gets its default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        to_cnt_d    = to_cnt_q;
        settle_d    = settle_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        timeout_set = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable_i && !fifo_empty && !err_q) begin
                    adr_d    = ADDR_X;
                    dat_d    = fifo_mem[rd_ptr_q[PTR_W-1:0]];
                    we_d     = 1'b1;
                    cyc_d    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = ST_WR;
                end
            end
            ST_WR: begin
                if (wbm_ack_i) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    dat_d = '0;
                    pop   = 1'b1;
                    if (SETTLE_CYCLES == 0) begin
                        adr_d    = ADDR_Y;
                        cyc_d    = 1'b1;
                        to_cnt_d = '0;
                        state_d  = ST_RD;
                    end else begin
                        settle_d = ST_W'(SETTLE_CYCLES - 1);
                        state_d  = ST_SETTLE;
                    end
                end else if (to_hit) begin
                    // The head stays in the FIFO so it is retried once the error clears.
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    dat_d       = '0;
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    adr_d    = ADDR_Y;
                    we_d     = 1'b0;
                    cyc_d    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = ST_RD;
                end else begin
                    settle_d = settle_q - ST_W'(1);
                end
            end
            ST_RD: begin
                if (wbm_ack_i) begin
                    cyc_d     = 1'b0;
                    m_data_d  = wbm_dat_i;
                    m_valid_d = 1'b1;
                    state_d   = ST_OUT;
                end else if (to_hit) begin
                    cyc_d       = 1'b0;
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_OUT: begin
                if (m_ready_i) begin
                    m_valid_d = 1'b0;
                    cnt_d     = cnt_q + 16'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new timeout outranks a simultaneous clear request.
        if (timeout_set) begin
            err_d = 1'b1;
        end else if (clear_err_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            to_cnt_q  <= '0;
            settle_q  <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            to_cnt_q  <= to_cnt_d;
            settle_q  <= settle_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign wbm_adr_o     = adr_q;
    assign wbm_dat_o     = dat_q;
    assign wbm_we_o      = we_q;
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = cyc_q;
    assign m_data_o      = m_data_q;
    assign m_valid_o     = m_valid_q;
    assign sample_cnt_o  = cnt_q;
    assign timeout_err_o = err_q;
    assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;

endmodule
